// File: rtl/arena_pkg.sv
// Shared arena definitions: graph size, path depth, directions and the
// node adjacency table used by path planning and path mapping.
package arena_pkg;

    localparam int NODE_COUNT = 30;
    localparam int PATH_DEPTH = 16;
    localparam logic [4:0] NO_EDGE = 5'd31;

    typedef enum logic [1:0] {
        DIR_N = 2'd0,
        DIR_E = 2'd1,
        DIR_S = 2'd2,
        DIR_W = 2'd3
    } dir_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_INIT = 3'd1,
        ST_DEQ  = 3'd2,
        ST_EXP  = 3'd3,
        ST_BACK = 3'd4,
        ST_EMIT = 3'd5,
        ST_DONE = 3'd6
    } plan_state_e;

    // One row per node, packed {N, E, S, W}; 31 marks a missing edge.
    localparam logic [19:0] ADJ_ROM [NODE_COUNT] = '{
        {5'd31, 5'd1,  5'd31, 5'd31},
        {5'd29, 5'd2,  5'd31, 5'd0 },
        {5'd31, 5'd3,  5'd31, 5'd1 },
        {5'd31, 5'd4,  5'd28, 5'd2 },
        {5'd31, 5'd5,  5'd31, 5'd3 },
        {5'd31, 5'd6,  5'd31, 5'd4 },
        {5'd31, 5'd7,  5'd31, 5'd5 },
        {5'd31, 5'd8,  5'd31, 5'd6 },
        {5'd31, 5'd9,  5'd31, 5'd7 },
        {5'd10, 5'd11, 5'd31, 5'd8 },
        {5'd31, 5'd31, 5'd9,  5'd31},
        {5'd31, 5'd12, 5'd31, 5'd9 },
        {5'd31, 5'd13, 5'd31, 5'd11},
        {5'd31, 5'd14, 5'd31, 5'd12},
        {5'd31, 5'd15, 5'd31, 5'd13},
        {5'd31, 5'd16, 5'd31, 5'd14},
        {5'd31, 5'd17, 5'd31, 5'd15},
        {5'd31, 5'd18, 5'd31, 5'd16},
        {5'd31, 5'd19, 5'd31, 5'd17},
        {5'd31, 5'd31, 5'd31, 5'd18},
        {5'd31, 5'd21, 5'd31, 5'd29},
        {5'd31, 5'd22, 5'd31, 5'd20},
        {5'd31, 5'd23, 5'd31, 5'd21},
        {5'd31, 5'd24, 5'd31, 5'd22},
        {5'd31, 5'd25, 5'd31, 5'd23},
        {5'd31, 5'd31, 5'd31, 5'd24},
        {5'd28, 5'd27, 5'd31, 5'd31},
        {5'd31, 5'd31, 5'd31, 5'd26},
        {5'd3,  5'd31, 5'd26, 5'd31},
        {5'd31, 5'd20, 5'd1,  5'd31}
    };

    function automatic logic [4:0] adj_nb(
        input logic [4:0] node,
        input dir_e       dir
    );
        logic [19:0] w_row;
        logic [4:0]  w_nb;
        w_row = {4{NO_EDGE}};
        if (node < 5'(NODE_COUNT)) begin
            w_row = ADJ_ROM[node];
        end
        unique case (dir)
            DIR_N:   w_nb = w_row[19:15];
            DIR_E:   w_nb = w_row[14:10];
            DIR_S:   w_nb = w_row[9:5];
            default: w_nb = w_row[4:0];
        endcase
        return w_nb;
    endfunction

endpackage

// File: rtl/path_planner_fifo.sv
// 32-entry node queue for the breadth-first search frontier.
module node_fifo
    import arena_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_clr,
    input  logic       i_push,
    input  logic [4:0] i_din,
    input  logic       i_pop,
    output logic [4:0] o_dout,
    output logic       o_empty
);

    logic [4:0] r_mem [32];
    logic [4:0] r_head;
    logic [4:0] r_tail;

    // Clearing drops stale entries by catching head up to tail, so a
    // push in the same cycle becomes the only entry.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_head <= 5'd0;
            r_tail <= 5'd0;
        end else begin
            if (i_push) begin
                r_tail <= r_tail + 5'd1;
            end
            if (i_clr) begin
                r_head <= r_tail;
            end else if (i_pop) begin
                r_head <= r_head + 5'd1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_tail] <= i_din;
        end
    end

    assign o_dout  = r_mem[r_head];
    assign o_empty = (r_head == r_tail);

endmodule

// File: rtl/path_planner.sv
// Breadth-first minimum-hop route search over the arena graph; streams
// the route start-first into the path-mapping load interface.
module path_planner
    import arena_pkg::*;
(
    input  logic       clk_3125KHz,
    input  logic       reset,
    input  logic       start,
    input  logic [4:0] start_node,
    input  logic [4:0] end_node,
    output logic       busy,
    output logic       path_input,
    output logic [4:0] path_planned,
    output logic [4:0] path_len,
    output logic       path_done,
    output logic       error
);

    localparam logic [4:0] NODES5 = 5'(NODE_COUNT);
    localparam logic [4:0] DEPTH5 = 5'(PATH_DEPTH);

    plan_state_e r_state;
    plan_state_e w_next;

    logic [4:0]            r_start;
    logic [4:0]            r_end;
    logic [4:0]            r_cur;
    dir_e                  r_dir;
    logic [4:0]            r_sp;
    logic [4:0]            r_len;
    logic                  r_err;
    logic [NODE_COUNT-1:0] r_visited;
    logic [4:0]            r_parent [NODE_COUNT];
    logic [4:0]            r_stack [PATH_DEPTH];

    logic [4:0] w_nb;
    logic       w_nb_new;
    logic       w_bad_node;
    logic       w_fail;
    logic [3:0] w_top;
    logic       w_clr;
    logic       w_push;
    logic       w_pop;
    logic [4:0] w_fifo_din;
    logic [4:0] w_fifo_dout;
    logic       w_fifo_empty;

    node_fifo u_fifo (
        .i_clk   (clk_3125KHz),
        .i_reset (reset),
        .i_clr   (w_clr),
        .i_push  (w_push),
        .i_din   (w_fifo_din),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_dout),
        .o_empty (w_fifo_empty)
    );

    assign w_nb       = adj_nb(r_cur, r_dir);
    assign w_nb_new   = (w_nb < NODES5) && !r_visited[w_nb];
    assign w_bad_node = (r_start >= NODES5) || (r_end >= NODES5);
    assign w_top      = 4'(r_sp - 5'd1);

    always_ff @(posedge clk_3125KHz) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_clr      = 1'b0;
        w_push     = 1'b0;
        w_pop      = 1'b0;
        w_fifo_din = r_start;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = ST_INIT;
                end
            end
            ST_INIT: begin
                if (w_bad_node) begin
                    w_next = ST_DONE;
                end else begin
                    w_clr  = 1'b1;
                    w_push = 1'b1;
                    w_next = ST_DEQ;
                end
            end
            ST_DEQ: begin
                if (w_fifo_empty) begin
                    w_next = ST_DONE;
                end else begin
                    w_pop  = 1'b1;
                    w_next = (w_fifo_dout == r_end) ? ST_BACK : ST_EXP;
                end
            end
            ST_EXP: begin
                w_fifo_din = w_nb;
                w_push     = w_nb_new;
                if (r_dir == DIR_W) begin
                    w_next = ST_DEQ;
                end
            end
            ST_BACK: begin
                if (r_sp == DEPTH5) begin
                    w_next = ST_DONE;
                end else if (r_cur == r_start) begin
                    w_next = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (r_sp == 5'd1) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Every way into DONE other than a finished stream is a failure.
    assign w_fail = (w_next == ST_DONE) && (r_state != ST_EMIT);

    always_ff @(posedge clk_3125KHz) begin
        if (reset) begin
            r_start   <= 5'd0;
            r_end     <= 5'd0;
            r_cur     <= 5'd0;
            r_dir     <= DIR_N;
            r_sp      <= 5'd0;
            r_len     <= 5'd0;
            r_err     <= 1'b0;
            r_visited <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_start <= start_node;
                        r_end   <= end_node;
                        r_err   <= 1'b0;
                        r_len   <= 5'd0;
                    end
                end
                ST_INIT: begin
                    r_visited <= {{(NODE_COUNT-1){1'b0}}, 1'b1} << r_start;
                    r_sp      <= 5'd0;
                end
                ST_DEQ: begin
                    r_cur <= w_fifo_dout;
                    r_dir <= DIR_N;
                end
                ST_EXP: begin
                    if (w_nb_new) begin
                        r_visited[w_nb] <= 1'b1;
                    end
                    r_dir <= dir_e'(r_dir + 2'd1);
                end
                ST_BACK: begin
                    if (r_sp != DEPTH5) begin
                        r_sp <= r_sp + 5'd1;
                        if (r_cur == r_start) begin
                            r_len <= r_sp + 5'd1;
                        end else begin
                            r_cur <= r_parent[r_cur];
                        end
                    end
                end
                ST_EMIT: begin
                    r_sp <= r_sp - 5'd1;
                end
                default: begin
                end
            endcase
            if (w_fail) begin
                r_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_3125KHz) begin
        if (r_state == ST_EXP && w_nb_new) begin
            r_parent[w_nb] <= r_cur;
        end
        if (r_state == ST_BACK && r_sp != DEPTH5) begin
            r_stack[r_sp[3:0]] <= r_cur;
        end
    end

    assign busy         = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign path_input   = (r_state == ST_EMIT);
    assign path_planned = path_input ? r_stack[w_top] : 5'd0;
    assign path_len     = r_len;
    assign path_done    = (r_state == ST_DONE);
    assign error        = r_err;

endmodule
